reg_to_mem: RTL and testbench
=============================

REG_TO_MEM -- requirements
Module: reg_to_mem

Interface
REQ-001 Parameter DATA_BITS, default 32, SHALL set the data and address width.
REQ-002 Parameter DEPTH, default 2, SHALL set the store-buffer entry count; it is fixed at 2 in this revision.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid  in  1  SHALL mean a store request is presented.
REQ-006 req_ready  out  1  SHALL mean a request can be accepted this cycle.
REQ-007 req_addr  in  DATA_BITS  SHALL be the byte address computed by the ALU.
REQ-008 req_data  in  DATA_BITS  SHALL be the register value to store (rt).
REQ-009 req_size  in  2  SHALL encode the store size: 0 word, 1 byte, 2 halfword, 3 undefined.
REQ-010 mem_valid  out  1  SHALL mean a write is presented to data memory.
REQ-011 mem_ready  in  1  SHALL mean memory accepts the write this cycle.
REQ-012 mem_addr  out  DATA_BITS  SHALL be the word-aligned address, with bits [1:0] = 0.
REQ-013 mem_wdata  out  DATA_BITS  SHALL be the lane-aligned write data.
REQ-014 mem_be  out  4  SHALL be the byte enables; bit i enables byte lane i (bits 8i+7:8i).
REQ-015 misalign  out  1  SHALL be a one-cycle address-error pulse.
REQ-016 count  out  2  SHALL be the number of buffered entries.

Function
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-018 req_ready SHALL equal (count != 2); it SHALL NOT depend combinationally on mem_ready.
REQ-019 Byte store SHALL place req_data[7:0] in lane addr[1:0], zero all other lanes, and set mem_be = 1 << addr[1:0].
REQ-020 Halfword store SHALL:
- place req_data[15:0] in lanes 1:0 with mem_be = 0011 when addr[1] = 0;
- place it in lanes 3:2 with mem_be = 1100 when addr[1] = 1;
- zero the remaining lanes.
REQ-021 Word store SHALL pass req_data unchanged with mem_be = 1111.
REQ-022 A request SHALL be misaligned when it is a halfword with addr[0] = 1, a word with addr[1:0] != 0, or req_size = 3.
REQ-023 A misaligned request SHALL be consumed but not enqueued; misalign SHALL be 1 for exactly the cycle after acceptance, and buffer contents and count SHALL be unchanged.
REQ-024 Alignment, mem_be and mem_addr generation SHALL happen before enqueue; each entry SHALL hold {addr[31:2], wdata, be}.
REQ-025 The buffer SHALL be FIFO: mem_valid = (count != 0), and mem_addr, mem_wdata and mem_be SHALL come from the head entry.
REQ-026 Latency: a request accepted at edge N into an empty buffer SHALL give mem_valid = 1 after edge N, i.e. one cycle.
REQ-027 The head entry SHALL be popped on an edge with mem_valid and mem_ready both 1.
REQ-028 While mem_valid = 1 and mem_ready = 0, all mem_* outputs SHALL be held stable.
REQ-029 Count update rules:
- push and pop on the same edge: count unchanged, order preserved;
- push only: count + 1;
- pop only: count - 1.
REQ-030 At count = 2, req_ready SHALL be 0 even if mem_ready = 1 that cycle; the accept proceeds on the next cycle.
REQ-031 Read and write pointers SHALL be 1 bit each and wrap modulo 2.
REQ-032 Overflow and underflow SHALL be impossible; an assertion SHALL flag push at count 2 or pop at count 0.

Reset
REQ-033 While rst = 1, asynchronously: count = 0, both pointers = 0, mem_valid = 0, misalign = 0, req_ready = 1.
REQ-034 Reset asserted mid-transfer SHALL discard all buffered entries; no write SHALL be issued for them after reset releases.
REQ-035 Entry data storage SHALL NOT require reset; mem_addr, mem_wdata and mem_be are don't-care while mem_valid = 0.

Structure
REQ-036 A shared package SHALL hold:
- the store-size encodings SZ_WORD = 0, SZ_BYTE = 1, SZ_HALF = 2, SZ_UNDEF = 3, which match the load-extract encoding;
- the BE width constant (4).
REQ-037 The lane-alignment/byte-enable logic SHALL be a combinational sub-module store_align; the FIFO and handshake SHALL stay in reg_to_mem.

Verification
REQ-038 Byte store, addr = 0x1003, data = 0x000000A5, mem_ready = 1 -> next cycle mem_addr = 0x1000, mem_wdata = 0xA5000000, mem_be = 1000.
REQ-039 Halfword stores, addr = 0x2002 then 0x2000, data = 0x1234BEEF -> mem_wdata = 0xBEEF0000 with mem_be = 1100, then 0x0000BEEF with mem_be = 0011, in that order.
REQ-040 Word store to 0x3001 -> misalign pulses one cycle, mem_valid stays 0, count stays 0.
REQ-041 mem_ready held at 0, three back-to-back word stores -> two are accepted (count = 2, req_ready = 0) and outputs stay stable; release mem_ready -> all three are written in order.
REQ-042 Count = 1 with a simultaneous push and pop -> count remains 1 and the next entry appears the following cycle.
REQ-043 Assert rst with count = 2 and mem_ready = 0 -> mem_valid drops immediately; after release, no write occurs until a new request arrives.

Source files
------------

// File: rtl/reg_to_mem_pkg.sv
// Shared encodings for the store path. The store-size codes match the load-extract
// encoding, so a single decoder convention covers both directions.
package reg_to_mem_pkg;

   typedef enum logic [1:0] {
      SZ_WORD  = 2'd0,
      SZ_BYTE  = 2'd1,
      SZ_HALF  = 2'd2,
      SZ_UNDEF = 2'd3
   } size_e;

   localparam int BE_W = 4;

endpackage

// File: rtl/reg_to_mem_store_align.sv
// Combinational lane steering for stores: moves the register value into its byte
// lanes, builds byte enables and flags addresses that the access size cannot reach.
module store_align
   import reg_to_mem_pkg::*;
#(
   parameter int DATA_BITS = 32
) (
   input  logic [DATA_BITS-1:0] addr,
   input  logic [DATA_BITS-1:0] data,
   input  logic [1:0]           size,
   output logic [DATA_BITS-3:0] word_addr,
   output logic [DATA_BITS-1:0] wdata,
   output logic [BE_W-1:0]      be,
   output logic                 misalign
);

   always_comb begin
      word_addr = addr[DATA_BITS-1:2];
      wdata     = '0;
      be        = '0;
      misalign  = 1'b0;
      case (size)
         SZ_WORD: begin
            wdata    = data;
            be       = '1;
            misalign = (addr[1:0] != 2'b00);
         end
         SZ_BYTE: begin
            wdata = DATA_BITS'(data[7:0]) << {addr[1:0], 3'b000};
            be    = BE_W'(1) << addr[1:0];
         end
         SZ_HALF: begin
            wdata    = DATA_BITS'(data[15:0]) << {addr[1], 4'b0000};
            be       = addr[1] ? 4'b1100 : 4'b0011;
            misalign = addr[0];
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/reg_to_mem.sv
// Store path from the register file to data memory: aligns each store, then queues
// it in a two-entry FIFO that drives a valid/ready write port.
module reg_to_mem
   import reg_to_mem_pkg::*;
#(
   parameter int DATA_BITS = 32,
   parameter int DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [DATA_BITS-1:0] req_addr,
   input  logic [DATA_BITS-1:0] req_data,
   input  logic [1:0]           req_size,
   output logic                 mem_valid,
   input  logic                 mem_ready,
   output logic [DATA_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata,
   output logic [BE_W-1:0]      mem_be,
   output logic                 misalign,
   output logic [1:0]           count
);

   logic [DATA_BITS-3:0] word_addr_p0;
   logic [DATA_BITS-1:0] wdata_p0;
   logic [BE_W-1:0]      be_p0;
   logic                 mis_p0;

   logic [DATA_BITS-3:0] ent_addr_p1  [DEPTH];
   logic [DATA_BITS-1:0] ent_wdata_p1 [DEPTH];
   logic [BE_W-1:0]      ent_be_p1    [DEPTH];

   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count_q;
   logic       misalign_p1;
   logic       accept;
   logic       push;
   logic       pop;

   // Stage p0: alignment happens before enqueue, so entries hold write-ready beats.
   store_align #(.DATA_BITS(DATA_BITS)) u_align (
      .addr      (req_addr),
      .data      (req_data),
      .size      (req_size),
      .word_addr (word_addr_p0),
      .wdata     (wdata_p0),
      .be        (be_p0),
      .misalign  (mis_p0)
   );

   // Ready comes from occupancy alone, so a full buffer stalls even when memory drains.
   assign req_ready = (count_q != 2'(DEPTH));
   assign accept    = req_valid && req_ready;
   assign push      = accept && !mis_p0;
   assign pop       = mem_valid && mem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count_q     <= 2'd0;
         misalign_p1 <= 1'b0;
      end else begin
         misalign_p1 <= accept && mis_p0;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Stage p1: storage is unreset; an empty buffer masks it through mem_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr_p1[wr_ptr]  <= word_addr_p0;
         ent_wdata_p1[wr_ptr] <= wdata_p0;
         ent_be_p1[wr_ptr]    <= be_p0;
      end
   end

   assign mem_valid = (count_q != 2'd0);
   assign mem_addr  = {ent_addr_p1[rd_ptr], 2'b00};
   assign mem_wdata = ent_wdata_p1[rd_ptr];
   assign mem_be    = ent_be_p1[rd_ptr];
   assign misalign  = misalign_p1;
   assign count     = count_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && count_q == 2'(DEPTH)));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(pop && count_q == 2'd0));

endmodule

// File: tb/tb_reg_to_mem.sv
// Bench for reg_to_mem: directed scenarios with literal expectations, then random
// traffic compared each cycle against a queue-based model of the store buffer.
module tb_reg_to_mem;
   import reg_to_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [1:0]  req_size = '0;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        misalign;
   logic [1:0]  count;

   int total = 0;
   int bad   = 0;

   reg_to_mem #(.DATA_BITS(32), .DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_size  (req_size),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .misalign  (misalign),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } wr_t;

   wr_t q[$];
   bit  exp_mis = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Builds the memory beat lane by lane from the size/offset rules.
   function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] sz, output bit mis,
                                       output wr_t e);
      logic [7:0] lane [4];
      bit         en   [4];
      int         off;
      off = int'(a % 4);
      for (int i = 0; i < 4; i++) begin
         lane[i] = 8'h00;
         en[i]   = 1'b0;
      end
      mis = 1'b0;
      if (sz == 2'd0) begin
         mis = (off != 0);
         for (int i = 0; i < 4; i++) begin
            lane[i] = d[8*i +: 8];
            en[i]   = 1'b1;
         end
      end else if (sz == 2'd1) begin
         lane[off] = d[7:0];
         en[off]   = 1'b1;
      end else if (sz == 2'd2) begin
         mis = (off % 2 == 1);
         lane[(off / 2) * 2]     = d[7:0];
         lane[(off / 2) * 2 + 1] = d[15:8];
         en[(off / 2) * 2]       = 1'b1;
         en[(off / 2) * 2 + 1]   = 1'b1;
      end else begin
         mis = 1'b1;
      end
      e.addr  = a - 32'(off);
      e.wdata = '0;
      e.be    = '0;
      for (int i = 0; i < 4; i++) begin
         e.wdata = e.wdata | (32'(lane[i]) << (8 * i));
         if (en[i]) e.be = e.be | 4'(1 << i);
      end
   endfunction

   bit  m_acc, m_pop, m_mis;
   wr_t m_e;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         exp_mis = 1'b0;
      end else begin
         m_acc = req_valid && (q.size() != 2);
         m_pop = (q.size() != 0) && mem_ready;
         model_store(req_addr, req_data, req_size, m_mis, m_e);
         if (m_pop) void'(q.pop_front());
         if (m_acc && !m_mis) q.push_back(m_e);
         exp_mis = m_acc && m_mis;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("count", 32'(count), 32'(q.size()));
         chk("req_ready", 32'(req_ready), 32'(q.size() != 2));
         chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
         chk("misalign", 32'(misalign), 32'(exp_mis));
         if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].wdata);
            chk("mem_be", 32'(mem_be), 32'(q[0].be));
         end
      end
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_size  = s;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(mem_valid), 32'd0);
      chk("rst_mis", 32'(misalign), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;

      // Byte store to the top lane
      drive(32'h1003, 32'h0000_00A5, SZ_BYTE);
      mem_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("b_valid", 32'(mem_valid), 32'd1);
      chk("b_addr", mem_addr, 32'h0000_1000);
      chk("b_wdata", mem_wdata, 32'hA500_0000);
      chk("b_be", 32'(mem_be), 32'h8);
      @(negedge clk);
      chk("b_drained", 32'(mem_valid), 32'd0);

      // Two halfwords, upper then lower half, queued then drained
      mem_ready = 1'b0;
      drive(32'h2002, 32'h1234_BEEF, SZ_HALF);
      @(negedge clk);
      drive(32'h2000, 32'h1234_BEEF, SZ_HALF);
      @(negedge clk);
      req_valid = 1'b0;
      chk("h_count", 32'(count), 32'd2);
      chk("h1_wdata", mem_wdata, 32'hBEEF_0000);
      chk("h1_be", 32'(mem_be), 32'hC);
      mem_ready = 1'b1;
      @(negedge clk);
      chk("h2_wdata", mem_wdata, 32'h0000_BEEF);
      chk("h2_be", 32'(mem_be), 32'h3);
      @(negedge clk);
      chk("h_empty", 32'(count), 32'd0);

      // Misaligned word
      drive(32'h3001, 32'hDEAD_BEEF, SZ_WORD);
      @(negedge clk);
      req_valid = 1'b0;
      chk("m_pulse", 32'(misalign), 32'd1);
      chk("m_valid", 32'(mem_valid), 32'd0);
      chk("m_count", 32'(count), 32'd0);
      @(negedge clk);
      chk("m_end", 32'(misalign), 32'd0);

      // Back-pressure with a third store waiting, then drain with push+pop at count 1
      mem_ready = 1'b0;
      drive(32'h4000, 32'h1111_1111, SZ_WORD);
      @(negedge clk);
      drive(32'h4004, 32'h2222_2222, SZ_WORD);
      @(negedge clk);
      drive(32'h4008, 32'h3333_3333, SZ_WORD);
      @(negedge clk);
      chk("f_count", 32'(count), 32'd2);
      chk("f_ready", 32'(req_ready), 32'd0);
      chk("f_head", mem_wdata, 32'h1111_1111);
      @(negedge clk);
      chk("f_stable_d", mem_wdata, 32'h1111_1111);
      chk("f_stable_a", mem_addr, 32'h0000_4000);
      mem_ready = 1'b1;
      @(negedge clk);
      chk("f_second", mem_wdata, 32'h2222_2222);
      chk("f_cnt1", 32'(count), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("f_third", mem_wdata, 32'h3333_3333);
      chk("f_pp_cnt", 32'(count), 32'd1);
      @(negedge clk);
      chk("f_empty", 32'(count), 32'd0);

      // Reset while full and stalled
      mem_ready = 1'b0;
      drive(32'h5000, 32'h5555_5555, SZ_WORD);
      @(negedge clk);
      drive(32'h5004, 32'h6666_6666, SZ_WORD);
      @(negedge clk);
      req_valid = 1'b0;
      chk("r_full", 32'(count), 32'd2);
      #1 rst = 1'b1;
      #1;
      chk("r_valid", 32'(mem_valid), 32'd0);
      chk("r_count", 32'(count), 32'd0);
      chk("r_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("r_quiet", 32'(mem_valid), 32'd0);
      end

      // Random traffic
      repeat (2000) begin
         @(negedge clk);
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 199) == 0) rst = 1'b1;
         req_valid = ($urandom_range(0, 2) != 0);
         req_addr  = $urandom;
         if ($urandom_range(0, 1) == 1) req_addr[1:0] = 2'b00;
         req_data  = $urandom;
         req_size  = 2'($urandom_range(0, 3));
         mem_ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
